ibex_rf_wb_arbiter: RTL
=======================

// Module: ibex_rf_wb_arbiter
// PURPOSE
//  Write-back arbiter directly upstream of the latch-based register file's single write port.
//  Merges two write sources onto one registered we/waddr/wdata stream:
//   - single-cycle EX results (no backpressure);
//   - late LSU load data (valid/ready, buffered in a small FIFO).
//  Exports a pending-write scoreboard so ID can stall on RAW hazards against queued loads.
// PARAMETERS
//  DataWidth  32  width of write data
//  FifoDepth  2   LSU queue entries; power of two, >=2
//  RV32E      0   1: only addresses 0..15 legal
// PORTS
//  clk_int       in   1          clock
//  rst_ni        in   1          async reset, active-low
//  flush_i       in   1          discard all queued LSU writes
//  ex_valid_i    in   1          EX write request (always accepted)
//  ex_addr_i     in   5          EX destination register
//  ex_wdata_i    in   DataWidth  EX write data
//  lsu_valid_i   in   1          LSU write request
//  lsu_ready_o   out  1          LSU request accepted when valid&ready
//  lsu_addr_i    in   5          LSU destination register
//  lsu_wdata_i   in   DataWidth  LSU load data
//  rf_we_o       out  1          to regfile we_a_i
//  rf_waddr_o    out  5          to regfile waddr_a_i
//  rf_wdata_o    out  DataWidth  to regfile wdata_a_i
//  pend_o        out  32         bit i = a valid queued LSU entry targets register i
//  err_o         out  1          registered; illegal address seen (RV32E, addr[4]=1)
// BEHAVIOUR
//  - Reset values: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, pend_o=0, err_o=0; FIFO empty,
//    so lsu_ready_o=1 out of reset.
//  - rf_* outputs are flops: exactly 1 cycle from selection to rf_we_o.
//  - Writes to x0 are dropped on both sources:
//    - EX: no rf_we_o;
//    - LSU: handshake completes but nothing is queued.
//  - Per-cycle arbitration, fixed priority:
//    1) ex_valid_i && ex_addr_i!=0 -> EX drives rf_* next cycle.
//    2) Else if FIFO has a valid head -> pop head to rf_*.
//    3) Else if lsu_valid_i && lsu_addr_i!=0 && FIFO empty -> bypass LSU straight to rf_*,
//       not queued.
//    4) Else rf_we_o=0 next cycle; rf_waddr_o/rf_wdata_o hold their last values.
//  - lsu_ready_o = (count < FifoDepth); it does not depend on a same-cycle pop.
//  - FIFO pointers wrap modulo FifoDepth; count is 0..FifoDepth.
//    - Push and pop in the same cycle leave count unchanged.
//  - Ordering: EX data is always younger than any LSU data, including a same-cycle LSU request.
//    - An EX write to X kills every queued entry targeting X.
//    - A same-cycle LSU push to X is accepted but marked killed.
//    - Killed entries still occupy a slot; they pop with rf_we_o=0 and never write.
//  - pend_o: OR over non-killed valid entries of onehot(addr).
//    - Combinational from FIFO state; excludes bypassed and output-register writes.
//  - flush_i: all entries invalid and count=0 next cycle.
//    - A same-cycle LSU handshake is dropped.
//    - EX path and rf_* selection for that cycle are unaffected, but no FIFO pop is
//      selected (priority 2 is skipped).
//  - RV32E: any request with addr[4]=1:
//    - is dropped (EX: no write; LSU: handshake completes, nothing queued);
//    - sets err_o for one cycle.
//  - Reset mid-operation: FIFO, count, killed flags and outputs clear asynchronously.
//    Queued data is lost.
// TESTING
//  1. EX-only: ex_valid=1, addr=5, data=0xDEADBEEF -> next cycle rf_we=1, waddr=5,
//     wdata=0xDEADBEEF; pend_o=0.
//  2. Bypass: idle EX, empty FIFO, LSU addr=7, data=0x1234 -> ready=1, rf_we next cycle
//     with waddr=7; nothing queued.
//  3. Contention/full (FifoDepth=2): EX busy 4 cycles, LSU pushes addr 3 then 4 ->
//     - pend_o=0x18;
//     - ready=0 while the FIFO holds 2 entries;
//     - EX idle -> rf writes 3 then 4 in order, then pend_o=0.
//  4. Kill: queue LSU addr=9, then EX addr=9, data=0xA ->
//     - rf writes 0xA to x9; pend_o[9] clears;
//     - the later pop of the killed entry gives rf_we=0.
//  5. Zero/flush: EX or LSU addr=0 -> no rf_we; two queued entries + flush_i -> count=0,
//     pend_o=0, no LSU writes follow.
//  6. Reset with two entries queued -> all outputs 0, lsu_ready_o=1; RV32E=1, addr=16 ->
//     err_o pulses, no write.

Source files
------------

// File: rtl/ibex_rf_wb_arbiter_if.sv
// ibex_rf_wb_arbiter_if
//   Bundles the write-back arbiter's request, register-file and status signals.
//   master: the core side (EX/LSU/ID) that raises requests and observes results.
//   slave : the arbiter itself.
//   Signals
//     flush_i                          discard all queued LSU writes
//     ex_valid_i/ex_addr_i/ex_wdata_i  EX write request (always accepted)
//     lsu_valid_i/lsu_ready_o          LSU handshake
//     lsu_addr_i/lsu_wdata_i           LSU destination register and load data
//     rf_we_o/rf_waddr_o/rf_wdata_o    registered register-file write port
//     pend_o                           per-register pending queued load writes
//     err_o                            illegal (RV32E) address seen
interface ibex_rf_wb_arbiter_if #(
    parameter int unsigned DataWidth = 32
);
    logic                 flush_i;
    logic                 ex_valid_i;
    logic [4:0]           ex_addr_i;
    logic [DataWidth-1:0] ex_wdata_i;
    logic                 lsu_valid_i;
    logic                 lsu_ready_o;
    logic [4:0]           lsu_addr_i;
    logic [DataWidth-1:0] lsu_wdata_i;
    logic                 rf_we_o;
    logic [4:0]           rf_waddr_o;
    logic [DataWidth-1:0] rf_wdata_o;
    logic [31:0]          pend_o;
    logic                 err_o;

    modport master (
        output flush_i, ex_valid_i, ex_addr_i, ex_wdata_i,
        output lsu_valid_i, lsu_addr_i, lsu_wdata_i,
        input  lsu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, pend_o, err_o
    );

    modport slave (
        input  flush_i, ex_valid_i, ex_addr_i, ex_wdata_i,
        input  lsu_valid_i, lsu_addr_i, lsu_wdata_i,
        output lsu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, pend_o, err_o
    );
endinterface

// File: rtl/ibex_rf_wb_arbiter.sv
// ibex_rf_wb_arbiter
//   Merges single-cycle EX results and buffered LSU load data onto the register
//   file's single registered write port. EX has fixed priority, then the LSU queue
//   head, then a direct LSU bypass when the queue is empty. Exports a scoreboard of
//   registers targeted by live queued loads.
//   Ports
//     clk_int  clock
//     rst_ni   asynchronous active-low reset
//     bus      ibex_rf_wb_arbiter_if.slave (requests, rf write port, pend/err)
module ibex_rf_wb_arbiter #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned FifoDepth = 2,
    parameter bit          RV32E     = 1'b0
) (
    input logic                 clk_int,
    input logic                 rst_ni,
    ibex_rf_wb_arbiter_if.slave bus
);
    localparam int unsigned     PtrW    = $clog2(FifoDepth);
    localparam logic [PtrW:0]   FullCnt = (PtrW+1)'(FifoDepth);

    logic [4:0]           q_addr [FifoDepth];
    logic [DataWidth-1:0] q_data [FifoDepth];
    logic [FifoDepth-1:0] q_vld;
    logic [FifoDepth-1:0] q_kill;
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [PtrW:0]        count;

    logic                 ex_ill, lsu_ill;
    logic                 ex_sel, lsu_ready, lsu_hs, lsu_ok;
    logic                 fifo_empty, pop, bypass, push, push_kill;
    logic [31:0]          pend;

    logic                 rf_we_q;
    logic [4:0]           rf_waddr_q;
    logic [DataWidth-1:0] rf_wdata_q;
    logic                 err_q;

    always_comb begin
        ex_ill     = RV32E && bus.ex_addr_i[4];
        lsu_ill    = RV32E && bus.lsu_addr_i[4];
        lsu_ready  = (count < FullCnt);
        fifo_empty = (count == '0);
        ex_sel     = bus.ex_valid_i && (bus.ex_addr_i != '0) && !ex_ill;
        lsu_hs     = bus.lsu_valid_i && lsu_ready;
        // A flush drops the same-cycle LSU handshake entirely, bypass included.
        lsu_ok     = lsu_hs && (bus.lsu_addr_i != '0) && !lsu_ill && !bus.flush_i;
        pop        = !ex_sel && !fifo_empty && !bus.flush_i;
        bypass     = !ex_sel && fifo_empty && lsu_ok;
        push       = lsu_ok && !bypass;
        // EX is younger than a same-cycle LSU write to the same register.
        push_kill  = ex_sel && (bus.ex_addr_i == bus.lsu_addr_i);
    end

    always_comb begin
        pend = '0;
        for (int unsigned i = 0; i < FifoDepth; i++) begin
            if (q_vld[i] && !q_kill[i]) pend[q_addr[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            q_vld  <= '0;
            q_kill <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FifoDepth; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
            end
        end else if (bus.flush_i) begin
            q_vld  <= '0;
            q_kill <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (ex_sel) begin
                for (int unsigned i = 0; i < FifoDepth; i++) begin
                    if (q_vld[i] && (q_addr[i] == bus.ex_addr_i)) q_kill[i] <= 1'b1;
                end
            end
            if (pop) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (push) begin
                q_vld[wr_ptr]  <= 1'b1;
                q_kill[wr_ptr] <= push_kill;
                q_addr[wr_ptr] <= bus.lsu_addr_i;
                q_data[wr_ptr] <= bus.lsu_wdata_i;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Address/data only update on a real write; killed pops and idle cycles hold them.
    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q   <= (bus.ex_valid_i && ex_ill) || (lsu_hs && lsu_ill);
            rf_we_q <= 1'b0;
            if (ex_sel) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= bus.ex_addr_i;
                rf_wdata_q <= bus.ex_wdata_i;
            end else if (pop) begin
                if (!q_kill[rd_ptr]) begin
                    rf_we_q    <= 1'b1;
                    rf_waddr_q <= q_addr[rd_ptr];
                    rf_wdata_q <= q_data[rd_ptr];
                end
            end else if (bypass) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= bus.lsu_addr_i;
                rf_wdata_q <= bus.lsu_wdata_i;
            end
        end
    end

    assign bus.lsu_ready_o = lsu_ready;
    assign bus.rf_we_o     = rf_we_q;
    assign bus.rf_waddr_o  = rf_waddr_q;
    assign bus.rf_wdata_o  = rf_wdata_q;
    assign bus.pend_o      = pend;
    assign bus.err_o       = err_q;
endmodule
